dm_arbiter: RTL and testbench
=============================

// Module: dm_arbiter
// PURPOSE
//  Two-port arbiter/sequencer in front of the single-ported 8K x 16 data memory
//  (negedge read/write; re and we mutually exclusive). Port 0 = CPU data port,
//  port 1 = DMA/accelerator. Grants one access per cycle, registers the DM
//  command and returns read data with a per-port valid pulse.
// PARAMETERS
//  ADDR_W     16    address width of requesters and DM
//  DATA_W     16    data width
//  MEM_DEPTH  8192  implemented words; addr >= MEM_DEPTH is out-of-range
//  AGE_LIMIT  8     port-1 wait cycles before a forced grant (DM_ARB_AGE_EN only)
// PORTS
//  clk         in   1       system clock; all state on posedge
//  rst_n       in   1       asynchronous active-low reset
//  pN_req      in   1       N=0,1: request valid; hold until pN_gnt
//  pN_we       in   1       1=write, 0=read
//  pN_addr     in   ADDR_W  word address
//  pN_wdata    in   DATA_W  write data
//  pN_gnt      out  1       request accepted this cycle (combinational)
//  pN_rvalid   out  1       one-cycle pulse: pN_rdata valid
//  pN_rdata    out  DATA_W  read data, held until next pN_rvalid
//  oob_err     out  1       one-cycle pulse: accepted request was out-of-range
//  dm_addr     out  ADDR_W  registered DM address
//  dm_re       out  1       registered DM read enable
//  dm_we       out  1       registered DM write enable
//  dm_wdata    out  DATA_W  registered DM write data
//  dm_rd_data  in   DATA_W  DM read data (updated on negedge)
// BEHAVIOUR
//  - Reset: all outputs 0, pipeline empty, age counter 0; applies mid-operation:
//    in-flight reads dropped, no rvalid/oob_err pulse after reset release.
//  - Arbitration (comb.): p0_req wins; p1_gnt = p1_req & ~p0_req. Never both gnt.
//  - Accept edge E0 (req&gnt): register dm_addr/dm_wdata; dm_re=~we, dm_we=we,
//    each for exactly one cycle; both 0 when idle. dm_re&dm_we never both 1.
//  - DM executes at negedge after E0; at E1 arbiter captures dm_rd_data into
//    pN_rdata of the issuing port, pN_rvalid=1 for cycle after E1.
//    Read latency: rvalid 2 cycles after gnt. Throughput 1 access/cycle,
//    back-to-back reads from alternating ports return in issue order.
//  - Writes produce no rvalid. Write then read of same addr on consecutive
//    grants returns new data.
//  - Out-of-range (addr >= MEM_DEPTH): accepted, dm_re=dm_we=0, no DM access;
//    reads return rdata=0 with rvalid at normal latency; oob_err pulses at E1.
//  - Pipeline regs: s1_vld, s1_port, s1_rd, s1_oob -> s2 (rvalid stage).
// CONFIGURATION
//  DM_ARB_AGE_EN defined: 4-bit age counter counts cycles p1_req&~p1_gnt;
//   clears on p1_gnt or ~p1_req. When count==AGE_LIMIT, next arbitration
//   gives p1 priority for one grant (p0_gnt=0 that cycle), then counter clears.
//  DM_ARB_AGE_EN undefined: pure fixed priority; p1 can starve; no counter.
// STRUCTURE
//  Package dm_arb_pkg: ADDR_W/DATA_W/MEM_DEPTH defaults, typedef port_id_t
//   (PORT_CPU=0, PORT_DMA=1), typedef dm_cmd_t {addr, wdata, re, we}.
//  Sub-module dm_arb_age (age counter + force flag), instantiated only under
//   DM_ARB_AGE_EN. Grant logic and pipeline stay in dm_arbiter.
// TESTING
//  1 Reset: rst_n=0 mid-read -> no p0_rvalid after release; all outputs 0.
//  2 p0 write 0x0010=0xBEEF, then p0 read 0x0010 -> dm_we 1 cycle, p0_rvalid
//    2 cycles after read gnt, p0_rdata=0xBEEF.
//  3 p0 and p1 req same cycle -> p0_gnt=1,p1_gnt=0; p1 gnt next cycle after p0
//    drops; dm_re/dm_we never both 1 (assertion).
//  4 Alternating p0 rd 0x0001 / p1 rd 0x0002 each cycle -> rvalid in issue
//    order, correct data to each port, one DM access/cycle.
//  5 p1 read addr 0x2000 -> no dm_re, p1_rvalid with rdata=0, oob_err pulse.
//  6 DM_ARB_AGE_EN, p0_req held high, p1_req high -> p1_gnt after 8 waiting
//    cycles, p0_gnt=0 that cycle; without macro p1_gnt never asserts.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// Shared types and defaults for the two-port data-memory arbiter.
// Latency: none (declarations only).
// Backpressure: n/a.
// Macro DM_ARB_AGE_EN (used by dm_arbiter) enables DMA-port aging.
package dm_arb_pkg;

  localparam int DM_ADDR_W    = 16;
  localparam int DM_DATA_W    = 16;
  localparam int DM_MEM_DEPTH = 8192;
  localparam int DM_AGE_LIMIT = 8;
  localparam int AGE_CNT_W    = 4;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DMA = 1'b1
  } port_id_t;

  // One registered DM command; re/we are one-hot or both clear.
  typedef struct packed {
    logic [DM_ADDR_W-1:0] addr;
    logic [DM_DATA_W-1:0] wdata;
    logic                 re;
    logic                 we;
  } dm_cmd_t;

endpackage

// File: rtl/dm_arb_age.sv
// Age counter for the DMA port: raises force_o once port 1 has waited AGE_LIMIT cycles.
// Latency: force_o is registered state, valid the cycle after the limit is reached.
// Backpressure: counts only while p1_req is held and not granted; clears on grant or drop.
// Ports: clk/rst_n; p1_req_i, p1_gnt_i (observed arbitration); force_o (priority flip).
// Only instantiated when DM_ARB_AGE_EN is defined.
module dm_arb_age
  import dm_arb_pkg::*;
#(
  parameter int AGE_LIMIT = DM_AGE_LIMIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic p1_req_i,
  input  logic p1_gnt_i,
  output logic force_o
);

  logic [AGE_CNT_W-1:0] age_q, age_d;

  // Saturates at the limit; the forced grant that follows clears it.
  always_comb begin
    age_d = age_q;
    if (!p1_req_i || p1_gnt_i) begin
      age_d = '0;
    end else if (age_q != AGE_LIMIT[AGE_CNT_W-1:0]) begin
      age_d = age_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end

  assign force_o = (age_q == AGE_LIMIT[AGE_CNT_W-1:0]);

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of the single-ported data memory (port 0 CPU, port 1 DMA).
// Latency: grant combinational; DM command 1 cycle after grant; rvalid 2 cycles after grant.
// Backpressure: requesters hold pN_req until pN_gnt; one access accepted per cycle.
// Ports: clk, rst_n; pN_req/we/addr/wdata in, pN_gnt/rvalid/rdata out (N=0,1);
//        oob_err out; dm_addr/re/we/wdata out (registered); dm_rd_data in (negedge DM).
// Macro DM_ARB_AGE_EN: port 1 gets one forced grant after AGE_LIMIT waiting cycles;
// undefined, port 0 has strict priority and port 1 can starve.
// ADDR_W/DATA_W must match the package widths because the command uses dm_cmd_t.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W    = DM_ADDR_W,
  parameter int DATA_W    = DM_DATA_W,
`ifdef DM_ARB_AGE_EN
  parameter int AGE_LIMIT = DM_AGE_LIMIT,
`endif
  parameter int MEM_DEPTH = DM_MEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              oob_err,
  output logic [ADDR_W-1:0] dm_addr,
  output logic              dm_re,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rd_data
);

  // ---------------- arbitration ----------------
  logic p1_force;
  logic p1_pri;

`ifdef DM_ARB_AGE_EN
  dm_arb_age #(
    .AGE_LIMIT(AGE_LIMIT)
  ) u_age (
    .clk      (clk),
    .rst_n    (rst_n),
    .p1_req_i (p1_req),
    .p1_gnt_i (p1_gnt),
    .force_o  (p1_force)
  );
`else
  assign p1_force = 1'b0;
`endif

  // p1_pri flips priority for exactly one cycle; grants stay mutually exclusive.
  assign p1_pri = p1_req & p1_force;
  assign p1_gnt = p1_req & (~p0_req | p1_pri);
  assign p0_gnt = p0_req & ~p1_pri;

  // ---------------- accepted request ----------------
  logic              acc;
  port_id_t          sel_port;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_oob;

  always_comb begin
    acc       = p0_gnt | p1_gnt;
    sel_port  = p1_gnt ? PORT_DMA : PORT_CPU;
    sel_we    = p1_gnt ? p1_we    : p0_we;
    sel_addr  = p1_gnt ? p1_addr  : p0_addr;
    sel_wdata = p1_gnt ? p1_wdata : p0_wdata;
    // Zero-extend both sides so the compare stays unsigned for any MEM_DEPTH.
    sel_oob   = (32'(sel_addr) >= 32'(MEM_DEPTH));
  end

  // ---------------- stage 1: DM command ----------------
  dm_cmd_t  cmd_q, cmd_d;
  logic     s1_vld_q, s1_vld_d;
  port_id_t s1_port_q, s1_port_d;
  logic     s1_rd_q, s1_rd_d;
  logic     s1_oob_q, s1_oob_d;

  // Out-of-range requests run through the pipeline but never touch the DM.
  always_comb begin
    cmd_d     = cmd_q;
    cmd_d.re  = 1'b0;
    cmd_d.we  = 1'b0;
    s1_vld_d  = acc;
    s1_port_d = sel_port;
    s1_rd_d   = ~sel_we;
    s1_oob_d  = sel_oob;
    if (acc) begin
      cmd_d.addr  = sel_addr;
      cmd_d.wdata = sel_wdata;
      cmd_d.re    = ~sel_we & ~sel_oob;
      cmd_d.we    =  sel_we & ~sel_oob;
    end
  end

  // ---------------- stage 2: read return ----------------
  logic              p0_rvalid_q, p0_rvalid_d;
  logic              p1_rvalid_q, p1_rvalid_d;
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
  logic              oob_err_q, oob_err_d;
  logic [DATA_W-1:0] rd_val;

  // dm_rd_data was refreshed at the negedge inside the stage-1 cycle.
  always_comb begin
    rd_val      = s1_oob_q ? '0 : dm_rd_data;
    p0_rvalid_d = s1_vld_q & s1_rd_q & (s1_port_q == PORT_CPU);
    p1_rvalid_d = s1_vld_q & s1_rd_q & (s1_port_q == PORT_DMA);
    p0_rdata_d  = p0_rvalid_d ? rd_val : p0_rdata_q;
    p1_rdata_d  = p1_rvalid_d ? rd_val : p1_rdata_q;
    oob_err_d   = s1_vld_q & s1_oob_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q       <= '0;
      s1_vld_q    <= 1'b0;
      s1_port_q   <= PORT_CPU;
      s1_rd_q     <= 1'b0;
      s1_oob_q    <= 1'b0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
      oob_err_q   <= 1'b0;
    end else begin
      cmd_q       <= cmd_d;
      s1_vld_q    <= s1_vld_d;
      s1_port_q   <= s1_port_d;
      s1_rd_q     <= s1_rd_d;
      s1_oob_q    <= s1_oob_d;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
      oob_err_q   <= oob_err_d;
    end
  end

  assign dm_addr   = cmd_q.addr;
  assign dm_wdata  = cmd_q.wdata;
  assign dm_re     = cmd_q.re;
  assign dm_we     = cmd_q.we;
  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign oob_err   = oob_err_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: drives both ports, emulates the negedge data memory.
// Latency: n/a.
// Backpressure: requests are held until granted.
module tb_dm_arbiter;
  import dm_arb_pkg::*;

  localparam int AW    = DM_ADDR_W;
  localparam int DW    = DM_DATA_W;
  localparam int DEPTH = DM_MEM_DEPTH;
  localparam int AGE   = DM_AGE_LIMIT;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
  logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, oob_err, dm_re, dm_we;
  logic [DW-1:0] p0_rdata, p1_rdata, dm_wdata;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_rd_data = '0;

  dm_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .oob_err(oob_err),
    .dm_addr(dm_addr), .dm_re(dm_re), .dm_we(dm_we), .dm_wdata(dm_wdata),
    .dm_rd_data(dm_rd_data)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Single-ported memory, executes at negedge.
  logic [DW-1:0] dm_mem  [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  always @(negedge clk) begin
    if (dm_re && int'(dm_addr) < DEPTH) dm_rd_data <= dm_mem[int'(dm_addr)];
    if (dm_we && int'(dm_addr) < DEPTH) dm_mem[int'(dm_addr)] <= dm_wdata;
  end

  // Reference: what each future cycle must show, filled in at grant time.
  typedef struct packed {
    logic re, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic rv0, rv1, oob;
    logic [DW-1:0] rd;
  } slot_t;

  slot_t         slots [4];
  int            cyc   = 0;
  int            wait1 = 0;
  logic [DW-1:0] hold0 = '0, hold1 = '0;

  always @(negedge clk) begin
    slot_t cur, tmp;
    bit force1, eg0, eg1, gw, goob;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    if (!rst_n) begin
      chk("rst_p0_gnt", p0_gnt, 0);       chk("rst_p1_gnt", p1_gnt, 0);
      chk("rst_dm_re", dm_re, 0);         chk("rst_dm_we", dm_we, 0);
      chk("rst_dm_addr", dm_addr, 0);     chk("rst_dm_wdata", dm_wdata, 0);
      chk("rst_p0_rvalid", p0_rvalid, 0); chk("rst_p1_rvalid", p1_rvalid, 0);
      chk("rst_p0_rdata", p0_rdata, 0);   chk("rst_p1_rdata", p1_rdata, 0);
      chk("rst_oob_err", oob_err, 0);
      for (int i = 0; i < 4; i++) slots[i] = '0;
      wait1 = 0; hold0 = '0; hold1 = '0;
    end else begin
      cur = slots[cyc % 4];
`ifdef DM_ARB_AGE_EN
      force1 = p1_req && (wait1 >= AGE);
`else
      force1 = 1'b0;
`endif
      eg1 = p1_req && (!p0_req || force1);
      eg0 = p0_req && !force1;
      chk("p0_gnt", p0_gnt, eg0);
      chk("p1_gnt", p1_gnt, eg1);
      chk("dm_re", dm_re, cur.re);
      chk("dm_we", dm_we, cur.we);
      chk("dm_re_we_excl", dm_re & dm_we, 0);
      if (cur.re || cur.we) chk("dm_addr", dm_addr, cur.addr);
      if (cur.we) chk("dm_wdata", dm_wdata, cur.wd);
      chk("p0_rvalid", p0_rvalid, cur.rv0);
      chk("p1_rvalid", p1_rvalid, cur.rv1);
      chk("oob_err", oob_err, cur.oob);
      if (cur.rv0) hold0 = cur.rd;
      if (cur.rv1) hold1 = cur.rd;
      chk("p0_rdata", p0_rdata, hold0);
      chk("p1_rdata", p1_rdata, hold1);
      if (eg0 || eg1) begin
        gw   = eg1 ? p1_we    : p0_we;
        ga   = eg1 ? p1_addr  : p0_addr;
        gd   = eg1 ? p1_wdata : p0_wdata;
        goob = int'(ga) >= DEPTH;
        tmp = slots[(cyc + 1) % 4];
        tmp.re = !gw && !goob; tmp.we = gw && !goob; tmp.addr = ga; tmp.wd = gd;
        slots[(cyc + 1) % 4] = tmp;
        tmp = slots[(cyc + 2) % 4];
        tmp.rv0 = !gw && !eg1; tmp.rv1 = !gw && eg1; tmp.oob = goob;
        tmp.rd  = (gw || goob) ? '0 : ref_mem[int'(ga)];
        slots[(cyc + 2) % 4] = tmp;
        if (gw && !goob) ref_mem[int'(ga)] = gd;
      end
      if (p1_req && !eg1) wait1++;
      else wait1 = 0;
      slots[cyc % 4] = '0;
    end
    cyc++;
  end

  // ---------------- driver ----------------
  bit            pend [2];
  bit            pwe  [2];
  logic [AW-1:0] paddr[2];
  logic [DW-1:0] pwd  [2];
  bit            s_g0, s_g1, s_rv0, s_rv1, s_oob, s_re, s_we;
  logic [DW-1:0] s_rd0, s_rd1;

  function automatic logic [AW-1:0] raddr();
    case ($urandom_range(0, 9))
      0:       return 16'h1FFF;
      1:       return 16'h2000 | 16'($urandom_range(0, 15));
      2:       return 16'($urandom);
      default: return 16'($urandom_range(0, 15));
    endcase
  endfunction

  task automatic issue(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend[p] = 1'b1; pwe[p] = we; paddr[p] = a; pwd[p] = d;
  endtask

  task automatic tick(input int pr0, input int pr1);
    @(posedge clk);
    #1;
    if (!pend[0] && int'($urandom_range(0, 99)) < pr0) issue(0, 1'($urandom_range(0, 1)), raddr(), 16'($urandom));
    if (!pend[1] && int'($urandom_range(0, 99)) < pr1) issue(1, 1'($urandom_range(0, 1)), raddr(), 16'($urandom));
    p0_req = pend[0]; p0_we = pwe[0]; p0_addr = paddr[0]; p0_wdata = pwd[0];
    p1_req = pend[1]; p1_we = pwe[1]; p1_addr = paddr[1]; p1_wdata = pwd[1];
    @(negedge clk);
    s_g0 = p0_gnt; s_g1 = p1_gnt; s_rv0 = p0_rvalid; s_rv1 = p1_rvalid;
    s_rd0 = p0_rdata; s_rd1 = p1_rdata; s_oob = oob_err; s_re = dm_re; s_we = dm_we;
    if (p0_gnt) pend[0] = 1'b0;
    if (p1_gnt) pend[1] = 1'b0;
  endtask

  // One access on an otherwise idle arbiter; lat counts cycles from grant to rvalid.
  task automatic do_access(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output int lat, output logic [DW-1:0] data, output int oobs, output int dmacc);
    lat = -1; data = '0; oobs = 0; dmacc = 0;
    issue(p, we, a, d);
    for (int i = 0; i < 10 && pend[p]; i++) tick(0, 0);
    chk("grant_timeout", pend[p], 0);
    for (int i = 1; i <= 4; i++) begin
      tick(0, 0);
      dmacc += int'(s_re) + int'(s_we);
      oobs  += int'(s_oob);
      if (lat < 0 && (p == 1 ? s_rv1 : s_rv0)) begin
        lat  = i;
        data = (p == 1) ? s_rd1 : s_rd0;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (pend[0] || pend[1]); i++) tick(0, 0);
    chk("drain_timeout", {pend[0], pend[1]}, 0);
    repeat (3) tick(0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, oobs, dmacc, n0, n1, nre, waits;
    logic [DW-1:0] data;
    bit g0_at;
    for (int i = 0; i < DEPTH; i++) begin
      dm_mem[i]  = 16'($urandom);
      ref_mem[i] = dm_mem[i];
    end
    pend[0] = 0; pend[1] = 0;
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;

    // Write then read back on port 0.
    do_access(0, 1'b1, 16'h0010, 16'hBEEF, lat, data, oobs, dmacc);
    chk("t2_wr_dm_cycles", dmacc, 1);
    chk("t2_wr_no_rvalid", lat, -1);
    do_access(0, 1'b0, 16'h0010, '0, lat, data, oobs, dmacc);
    chk("t2_rd_latency", lat, 2);
    chk("t2_rd_data", data, 16'hBEEF);

    // Out-of-range read on port 1, then the last implemented word.
    do_access(1, 1'b0, 16'h2000, '0, lat, data, oobs, dmacc);
    chk("t5_latency", lat, 2);
    chk("t5_rdata", data, 0);
    chk("t5_oob_pulses", oobs, 1);
    chk("t5_dm_access", dmacc, 0);
    do_access(1, 1'b1, 16'h1FFF, 16'h1234, lat, data, oobs, dmacc);
    do_access(1, 1'b0, 16'h1FFF, '0, lat, data, oobs, dmacc);
    chk("edge_rdata", data, 16'h1234);
    chk("edge_no_oob", oobs, 0);

    // Simultaneous requests.
    issue(0, 1'b0, 16'h0010, '0);
    issue(1, 1'b0, 16'h1FFF, '0);
    tick(0, 0);
    chk("t3_p0_wins", s_g0, 1);
    chk("t3_p1_waits", s_g1, 0);
    tick(0, 0);
    chk("t3_p1_next", s_g1, 1);
    drain();

    // Alternating reads from both ports.
    do_access(0, 1'b1, 16'h0001, 16'h1111, lat, data, oobs, dmacc);
    do_access(1, 1'b1, 16'h0002, 16'h2222, lat, data, oobs, dmacc);
    n0 = 0; n1 = 0; nre = 0;
    for (int i = 0; i < 11; i++) begin
      if (i < 8) begin
        if (i % 2 == 0) issue(0, 1'b0, 16'h0001, '0);
        else            issue(1, 1'b0, 16'h0002, '0);
      end
      tick(0, 0);
      nre += int'(s_re);
      if (s_rv0) begin n0++; chk("t4_rd0", s_rd0, 16'h1111); end
      if (s_rv1) begin n1++; chk("t4_rd1", s_rd1, 16'h2222); end
    end
    chk("t4_rv0_count", n0, 4);
    chk("t4_rv1_count", n1, 4);
    chk("t4_dm_reads", nre, 8);

    // Reset in the middle of a read.
    issue(0, 1'b0, 16'h0005, '0);
    tick(0, 0);
    chk("t1_gnt", s_g0, 1);
    tick(0, 0);
    chk("t1_dm_re", s_re, 1);
    #2 rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("t1_rvalid_in_reset", p0_rvalid, 0);
    chk("t1_dm_re_in_reset", dm_re, 0);
    #2 rst_n = 1'b1;
    n0 = 0;
    repeat (4) begin
      tick(0, 0);
      n0 += int'(s_rv0) + int'(s_oob);
    end
    chk("t1_no_pulse_after_reset", n0, 0);

    // Port 1 against a port 0 that never lets go.
    issue(1, 1'b0, 16'h0003, '0);
`ifdef DM_ARB_AGE_EN
    waits = 0; g0_at = 1'b1;
    for (int i = 0; i < 40 && pend[1]; i++) begin
      tick(100, 0);
      if (pend[1]) waits++;
      else g0_at = s_g0;
    end
    chk("t6_wait_cycles", waits, AGE);
    chk("t6_p0_blocked", g0_at, 0);
`else
    waits = 0;
    repeat (30) begin
      tick(100, 0);
      waits += int'(s_g1);
    end
    chk("t6_starved", waits, 0);
`endif
    drain();

    // Random traffic, light then heavy load.
    repeat (3000) tick(50, 35);
    repeat (1500) tick(90, 60);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
